// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI memory link: FSM state encoding, R/W bit values
// and the bit-index width used by both ends of the link.
package spi_master_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic RW_READ   = 1'b1;
  localparam logic RW_WRITE  = 1'b0;
  localparam int   BIT_IDX_W = 4;

endpackage

// File: rtl/spi_master_if.sv
// Host-side request/response signals plus the four SPI pins of the initiator.
interface spi_master_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              start;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              cs;
  logic              sclk;
  logic              mosi;
  logic              miso;

  modport master (
    input  start, rw, addr, wdata, miso,
    output busy, done, rdata, cs, sclk, mosi
  );

  modport slave (
    output start, rw, addr, wdata, miso,
    input  busy, done, rdata, cs, sclk, mosi
  );
endinterface

// File: rtl/spi_sclk_gen.sv
// SPI clock generator: CLK_DIV cycles per half-period, with one-cycle strobes
// on the clk edges where sclk is about to go high (rise_tick) or low (fall_tick).
module spi_sclk_gen #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);
  localparam int            CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap      = run && (cnt == CNT_MAX);
  assign rise_tick = wrap && !sclk;
  assign fall_tick = wrap && sclk;

  // clr looks at the next FSM state, so the wrap that ends a frame never raises sclk
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else if (run) begin
      cnt  <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/spi_master.sv
// SPI initiator: one 16-bit {addr, rw, data} frame per accepted start, MSB first,
// mosi launched on sclk fall and miso captured on sclk rise.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int CLK_DIV = 10,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8
) (
  input logic          clk,
  input logic          rst_n,
  spi_master_if.master bus
);
  localparam int                   FW         = ADDR_W + 1 + DATA_W;
  localparam logic [BIT_IDX_W-1:0] LAST_BIT   = BIT_IDX_W'(FW - 1);
  localparam logic [BIT_IDX_W-1:0] DATA_FIRST = BIT_IDX_W'(ADDR_W + 1);

  state_e               state, state_nx;
  logic [BIT_IDX_W-1:0] bit_idx;
  logic                 last_lo;
  logic                 rw_q;
  logic [FW-1:0]        shreg;
  logic [FW-1:0]        frame_in;
  logic                 mosi_q;
  logic [DATA_W-1:0]    rdata_q;
  logic                 run, clr, sclk_q, rise_tick, fall_tick, accept, finish;

  assign run      = (state == SETUP) || (state == SHIFT);
  assign clr      = !((state_nx == SETUP) || (state_nx == SHIFT));
  assign accept   = (state == IDLE) && bus.start;
  assign finish   = (state == SHIFT) && rise_tick && last_lo;
  assign frame_in = {bus.addr, bus.rw, (bus.rw == RW_READ) ? {DATA_W{1'b0}} : bus.wdata};

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .clr       (clr),
    .sclk      (sclk_q),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = SETUP;
      SETUP:   if (rise_tick) state_nx = SHIFT;
      SHIFT:   if (finish)    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // last_lo marks the low phase of the final bit; the next would-be rise ends the frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mosi_q  <= 1'b0;
      rdata_q <= '0;
      bit_idx <= '0;
      last_lo <= 1'b0;
    end else begin
      if (accept) begin
        mosi_q  <= frame_in[FW-1];
        bit_idx <= '0;
        last_lo <= 1'b0;
      end else if ((state == SHIFT) && fall_tick) begin
        if (bit_idx == LAST_BIT) begin
          last_lo <= 1'b1;
          mosi_q  <= 1'b0;
        end else begin
          bit_idx <= bit_idx + 1'b1;
          mosi_q  <= shreg[FW-1];
        end
      end
      if (finish && (rw_q == RW_READ)) rdata_q <= shreg[DATA_W-1:0];
    end
  end

  // Outgoing bits leave from the top while received bits enter at the bottom
  always_ff @(posedge clk) begin
    if (accept) begin
      rw_q  <= bus.rw;
      shreg <= {frame_in[FW-2:0], 1'b0};
    end else if (state == SHIFT) begin
      if (fall_tick && (bit_idx != LAST_BIT))
        shreg <= {shreg[FW-2:0], 1'b0};
      else if (rise_tick && !last_lo && (rw_q == RW_READ) && (bit_idx >= DATA_FIRST))
        shreg[0] <= bus.miso;
    end
  end

  assign bus.cs    = !run;
  assign bus.busy  = run;
  assign bus.done  = (state == DONE);
  assign bus.sclk  = sclk_q;
  assign bus.mosi  = mosi_q;
  assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: write/read frames, ignored starts, mid-frame
// reset and a CLK_DIV=4 instance, with a behavioural slave driving miso.
module tb_spi_master;
  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  spi_master_if #(.ADDR_W(7), .DATA_W(8)) bus ();
  spi_master_if #(.ADDR_W(7), .DATA_W(8)) bus4 ();

  spi_master #(.CLK_DIV(10), .ADDR_W(7), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  spi_master #(.CLK_DIV(4), .ADDR_W(7), .DATA_W(8)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor and slave model for the CLK_DIV=10 instance
  logic [15:0] mosi_cap = '0;
  logic        sclk_prev = 1'b0;
  int          cs_low = 0;
  int          done_cnt = 0;
  int          fcnt = 0;
  logic [7:0]  rbyte = 8'h00;

  always @(negedge clk) begin
    if (bus.sclk && !sclk_prev) mosi_cap = {mosi_cap[14:0], bus.mosi};
    if (!bus.cs) cs_low = cs_low + 1;
    if (bus.done) done_cnt = done_cnt + 1;
    if (bus.cs) begin
      fcnt     = 0;
      bus.miso = 1'b0;
    end else if (!bus.sclk && sclk_prev) begin
      fcnt = fcnt + 1;
      if (fcnt >= 8 && fcnt <= 15) bus.miso = rbyte[15 - fcnt];
    end
    sclk_prev = bus.sclk;
  end

  // Monitor for the CLK_DIV=4 instance
  logic [15:0] mosi_cap4 = '0;
  logic        sclk_prev4 = 1'b0;
  int          cs_low4 = 0;
  int          last_rise4 = 0;
  int          period4 = 0;

  always @(negedge clk) begin
    bus4.miso = 1'b0;
    if (bus4.sclk && !sclk_prev4) begin
      mosi_cap4  = {mosi_cap4[14:0], bus4.mosi};
      period4    = cyc - last_rise4;
      last_rise4 = cyc;
    end
    if (!bus4.cs) cs_low4 = cs_low4 + 1;
    sclk_prev4 = bus4.sclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; start stays high for exactly one cycle
  task automatic drive_start(input logic rw, input logic [6:0] addr, input logic [7:0] wdata,
                             output int t0);
    bus.rw    = rw;
    bus.addr  = addr;
    bus.wdata = wdata;
    bus.start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    bus.rw    = ~rw;
    bus.addr  = ~addr;
    bus.wdata = ~wdata;
  endtask

  task automatic wait_done(input bit sel4, input int t0, input int bound, output int rel);
    rel = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (sel4 ? bus4.done : bus.done) begin
        rel = cyc - t0;
        break;
      end
    end
  endtask

  int t0, t1, rel, cs0, d0;

  initial begin
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.rw     = 1'b0;
    bus.addr   = '0;
    bus.wdata  = '0;
    bus4.start = 1'b0;
    bus4.rw    = 1'b0;
    bus4.addr  = '0;
    bus4.wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_cs",    32'(bus.cs),    32'd1);
    check("rst_sclk",  32'(bus.sclk),  32'd0);
    check("rst_mosi",  32'(bus.mosi),  32'd0);
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_done",  32'(bus.done),  32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: write 0x55 <- 0xA3
    cs0 = cs_low;
    drive_start(1'b0, 7'h55, 8'hA3, t0);
    check("t1_busy", 32'(bus.busy), 32'd1);
    check("t1_cs",   32'(bus.cs),   32'd0);
    check("t1_mosi0", 32'(bus.mosi), 32'd1);
    wait_done(1'b0, t0, 500, rel);
    check("t1_done_cyc",  32'(rel), 32'd331);
    check("t1_done_cs",   32'(bus.cs), 32'd1);
    check("t1_done_busy", 32'(bus.busy), 32'd0);
    check("t1_rdata",     32'(bus.rdata), 32'd0);
    @(negedge clk);
    check("t1_mosi_bits", 32'(mosi_cap), 32'hAAA3);
    check("t1_cs_low",    32'(cs_low - cs0), 32'd330);

    // 2: read 0x12, slave returns 0xC5
    rbyte = 8'hC5;
    @(negedge clk);
    drive_start(1'b1, 7'h12, 8'hFF, t0);
    wait_done(1'b0, t0, 500, rel);
    check("t2_done_cyc", 32'(rel), 32'd331);
    check("t2_rdata",    32'(bus.rdata), 32'hC5);
    @(negedge clk);
    check("t2_mosi_bits", 32'(mosi_cap), 32'h2500);

    // 3: starts at 0, 50 and in the done cycle; restart at 332
    @(negedge clk);
    d0 = done_cnt;
    drive_start(1'b0, 7'h55, 8'hA3, t0);
    rel = -1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      bus.start = ((cyc - t0) == 50);
      if (bus.done) begin
        rel = cyc - t0;
        break;
      end
    end
    check("t3_done_cyc", 32'(rel), 32'd331);
    bus.start = 1'b1;
    bus.rw    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("t3_ignored_cs",   32'(bus.cs),   32'd1);
    check("t3_ignored_busy", 32'(bus.busy), 32'd0);
    check("t3_one_done",     32'(done_cnt - d0), 32'd1);
    check("t3_mosi_bits",    32'(mosi_cap), 32'hAAA3);
    drive_start(1'b0, 7'h01, 8'h02, t1);
    check("t3_restart_rel",  32'(t1 - t0), 32'd332);
    check("t3_restart_busy", 32'(bus.busy), 32'd1);
    wait_done(1'b0, t1, 500, rel);
    check("t3_restart_done", 32'(rel), 32'd331);
    check("t3_rdata_kept",   32'(bus.rdata), 32'hC5);
    @(negedge clk);
    check("t3_restart_bits", 32'(mosi_cap), 32'h0202);

    // 4: reset pulse at cycle 120 of a read
    rbyte = 8'h99;
    drive_start(1'b1, 7'h12, 8'h00, t0);
    while ((cyc - t0) < 120) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t4_cs",    32'(bus.cs),    32'd1);
    check("t4_sclk",  32'(bus.sclk),  32'd0);
    check("t4_mosi",  32'(bus.mosi),  32'd0);
    check("t4_busy",  32'(bus.busy),  32'd0);
    check("t4_rdata", 32'(bus.rdata), 32'd0);
    d0 = done_cnt;
    repeat (400) @(negedge clk);
    check("t4_no_done", 32'(done_cnt - d0), 32'd0);
    rbyte = 8'h5A;
    drive_start(1'b1, 7'h33, 8'h00, t0);
    wait_done(1'b0, t0, 500, rel);
    check("t4_fresh_done",  32'(rel), 32'd331);
    check("t4_fresh_rdata", 32'(bus.rdata), 32'h5A);
    @(negedge clk);
    check("t4_fresh_bits", 32'(mosi_cap), 32'h6700);

    // 6: CLK_DIV=4 instance, write addr 0 <- 0xFF
    cs0 = cs_low4;
    bus4.rw    = 1'b0;
    bus4.addr  = 7'h00;
    bus4.wdata = 8'hFF;
    bus4.start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    bus4.start = 1'b0;
    bus4.wdata = 8'h00;
    wait_done(1'b1, t0, 300, rel);
    check("t6_done_cyc", 32'(rel), 32'd133);
    @(negedge clk);
    check("t6_mosi_bits", 32'(mosi_cap4), 32'h00FF);
    check("t6_cs_low",    32'(cs_low4 - cs0), 32'd132);
    check("t6_period",    32'(period4), 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
